// File: rtl/ctrl_sequencer.sv
// Microprogram sequencer: steps through a range of 14-bit program words and
// presents each as a read-phase then a write-phase 7-bit ctrl word.
//
// state | meaning
// IDLE  | waiting for start; program memory loadable; ctrl held at 0
// RD    | read-phase word of instruction at pc on ctrl, phase = 0
// WR    | write-phase word of instruction at pc on ctrl, phase = 1
module ctrl_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          phi1,
   input  logic          notreset,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [13:0]   ld_data,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic [AW:0]   len,
   input  logic          halt,
   output logic [6:0]    ctrl,
   output logic          phase,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW:0]   rem_q, rem_d;
   logic [6:0]    ctrl_q, ctrl_d;
   logic          phase_q, phase_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [13:0]   mem_q [DEPTH];

   logic          mem_we;
   logic [13:0]   first_word;
   logic [AW-1:0] pc_inc;

   assign mem_we     = ld_en && (state_q == S_IDLE);
   // A word written in the same cycle as start must be visible immediately.
   assign first_word = (mem_we && (ld_addr == start_addr)) ? ld_data : mem_q[start_addr];
   assign pc_inc     = pc_q + AW'(1);

   always_ff @(posedge phi1 or negedge notreset) begin
      if (!notreset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[ld_addr] <= ld_data;
      end
   end

   always_ff @(posedge phi1 or negedge notreset) begin
      if (!notreset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         rem_q   <= '0;
         ctrl_q  <= '0;
         phase_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         rem_q   <= rem_d;
         ctrl_q  <= ctrl_d;
         phase_q <= phase_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      rem_d   = rem_q;
      ctrl_d  = '0;
      phase_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && (len != '0)) begin
               state_d = S_RD;
               pc_d    = start_addr;
               rem_d   = len;
               ctrl_d  = first_word[13:7];
               busy_d  = 1'b1;
            end else if (start) begin
               done_d = 1'b1;
            end
         end
         S_RD: begin
            if (halt) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WR;
               ctrl_d  = mem_q[pc_q][6:0];
               phase_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_WR: begin
            if (halt) begin
               state_d = S_IDLE;
            end else if (rem_q == (AW+1)'(1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = S_RD;
               pc_d    = pc_inc;
               rem_d   = rem_q - (AW+1)'(1);
               ctrl_d  = mem_q[pc_inc][13:7];
               busy_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ctrl  = ctrl_q;
   assign phase = phase_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: stimulus pushes expected
// {ctrl, phase, busy, done} tuples, a negedge monitor pops and compares.
module tb_ctrl_sequencer;

   logic        phi1 = 1'b0;
   logic        notreset;
   logic        ld_en;
   logic [3:0]  ld_addr;
   logic [13:0] ld_data;
   logic        start;
   logic [3:0]  start_addr;
   logic [4:0]  len;
   logic        halt;
   logic [6:0]  ctrl;
   logic        phase;
   logic        busy;
   logic        done;

   ctrl_sequencer #(.DEPTH(16), .AW(4)) dut (
      .phi1       (phi1),
      .notreset   (notreset),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .start      (start),
      .start_addr (start_addr),
      .len        (len),
      .halt       (halt),
      .ctrl       (ctrl),
      .phase      (phase),
      .busy       (busy),
      .done       (done)
   );

   always #5 phi1 = ~phi1;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic        mon_en  = 1'b0;
   logic [9:0]  exp_q [$];
   logic [13:0] model_mem [16];

   function automatic void check(string name, logic [9:0] act, logic [9:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void push(logic [6:0] c, logic p, logic b, logic d);
      exp_q.push_back({c, p, b, d});
   endfunction

   function automatic void push_run(logic [3:0] addr, int n);
      logic [3:0] a;
      for (int i = 0; i < n; i++) begin
         a = addr + 4'(i);
         push(model_mem[a][13:7], 1'b0, 1'b1, 1'b0);
         push(model_mem[a][6:0],  1'b1, 1'b1, 1'b0);
      end
      push(7'h00, 1'b0, 1'b0, 1'b1);
   endfunction

   always @(negedge phi1) begin
      if (mon_en) begin
         if (busy || done) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: got %h expected none at %0t",
                        {ctrl, phase, busy, done}, $time);
            end else begin
               check("seq_out", {ctrl, phase, busy, done}, exp_q.pop_front());
            end
         end else begin
            check("idle_out", {1'b0, ctrl, phase, 1'b0}, 10'h000);
         end
      end
   end

   task automatic tick(int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge phi1);
         #1;
      end
   endtask

   task automatic load(logic [3:0] a, logic [13:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      model_mem[a] = d;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic go(logic [3:0] a, logic [4:0] n);
      start = 1'b1; start_addr = a; len = n;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      notreset = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      start = 1'b0; start_addr = '0; len = '0; halt = 1'b0;
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
      tick(2);
      check("reset_state", {2'b0, ctrl, phase}, {2'b0, 7'h00, 1'b0});
      check("reset_flags", {8'b0, busy, done}, 10'h000);
      notreset = 1'b1;
      tick();

      // Asynchronous reset in the middle of a read phase.
      load(4'd3, 14'h1A5B);
      go(4'd3, 5'd1);
      check("pre_reset_rd", {2'b0, ctrl, phase}, {2'b0, 7'h34, 1'b0});
      #2 notreset = 1'b0;
      #1;
      check("async_reset", {ctrl, phase, busy, done}, 10'h000);
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
      #1 notreset = 1'b1;
      tick(2);
      check("post_reset_idle", {ctrl, phase, busy, done}, 10'h000);
      mon_en = 1'b1;

      // Single instruction, hand-computed halves of 14'h1A5B.
      load(4'd3, 14'h1A5B);
      push(7'h34, 1'b0, 1'b1, 1'b0);
      push(7'h5B, 1'b1, 1'b1, 1'b0);
      push(7'h00, 1'b0, 1'b0, 1'b1);
      go(4'd3, 5'd1);
      tick(3);

      // Wrap-around 15 -> 0 -> 1.
      load(4'd15, 14'h0123);
      load(4'd0,  14'h2A55);
      load(4'd1,  14'h1F0F);
      push(7'h02, 1'b0, 1'b1, 1'b0);
      push(7'h23, 1'b1, 1'b1, 1'b0);
      push(7'h54, 1'b0, 1'b1, 1'b0);
      push(7'h55, 1'b1, 1'b1, 1'b0);
      push(7'h3E, 1'b0, 1'b1, 1'b0);
      push(7'h0F, 1'b1, 1'b1, 1'b0);
      push(7'h00, 1'b0, 1'b0, 1'b1);
      go(4'd15, 5'd3);
      tick(7);

      // Halt in the second WR cycle: no done afterwards.
      load(4'd8, 14'h0AAA);
      load(4'd9, 14'h1555);
      push(7'h15, 1'b0, 1'b1, 1'b0);
      push(7'h2A, 1'b1, 1'b1, 1'b0);
      push(7'h2A, 1'b0, 1'b1, 1'b0);
      push(7'h55, 1'b1, 1'b1, 1'b0);
      go(4'd8, 5'd4);
      tick(3);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("halt_idle", {ctrl, phase, busy, done}, 10'h000);
      tick(4);

      // len = 0: done pulse only.
      push(7'h00, 1'b0, 1'b0, 1'b1);
      go(4'd2, 5'd0);
      check("len0_busy", {9'b0, busy}, 10'h000);
      tick(2);

      // start and ld_en while busy are both ignored.
      load(4'd12, 14'h1234);
      load(4'd13, 14'h0765);
      push_run(4'd12, 2);
      go(4'd12, 5'd2);
      tick();
      start = 1'b1; start_addr = 4'd0; len = 5'd1;
      ld_en = 1'b1; ld_addr = 4'd13; ld_data = 14'h3FFF;
      tick();
      start = 1'b0; ld_en = 1'b0;
      tick(3);
      push(7'h0E, 1'b0, 1'b1, 1'b0);
      push(7'h65, 1'b1, 1'b1, 1'b0);
      push(7'h00, 1'b0, 1'b0, 1'b1);
      go(4'd13, 5'd1);
      tick(3);

      // Same-cycle load/start bypass, then a zero-gap restart in the done cycle.
      push(7'h7F, 1'b0, 1'b1, 1'b0);
      push(7'h7F, 1'b1, 1'b1, 1'b0);
      push(7'h00, 1'b0, 1'b0, 1'b1);
      model_mem[5] = 14'h3FFF;
      ld_en = 1'b1; ld_addr = 4'd5; ld_data = 14'h3FFF;
      start = 1'b1; start_addr = 4'd5; len = 5'd1;
      tick();
      ld_en = 1'b0; start = 1'b0;
      tick(2);
      push(7'h34, 1'b0, 1'b1, 1'b0);
      push(7'h5B, 1'b1, 1'b1, 1'b0);
      push(7'h00, 1'b0, 1'b0, 1'b1);
      go(4'd3, 5'd1);
      tick(4);

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_expectations: got %0d left expected 0", exp_q.size());
      end
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
